// File: rtl/serial_sub_ctrl_if.sv
// Bus bundle for serial_sub_ctrl: request/result handshake plus the shared
// full-subtractor cell connections.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             fs_x;
  logic             fs_y;
  logic             fs_borin;
  logic             fs_diff;
  logic             fs_borout;

  // Controller side.
  modport slave (
    input  start, clear, a, b, fs_diff, fs_borout,
    output ready, busy, done, diff, borrow_out, fs_x, fs_y, fs_borin
  );

  // Requester side; it also hosts the external cell.
  modport master (
    output start, clear, a, b, fs_diff, fs_borout,
    input  ready, busy, done, diff, borrow_out, fs_x, fs_y, fs_borin
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller. Steps one external full-subtractor cell through
// the operand bits LSB first, recirculating the borrow in a flip-flop.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clock,
  input  logic               resetn,
  serial_sub_ctrl_if.slave   bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_bor;
  logic [CntW-1:0]  r_cnt;

  logic             w_last;
  logic             w_accept;
  logic             w_step;
  logic [WIDTH-1:0] w_res_next;

  assign w_last     = (r_cnt == LastCnt);
  assign w_accept   = (r_state == StIdle) && bus.start && !bus.clear;
  assign w_step     = (r_state == StRun) && !bus.clear;
  // Cell difference enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign w_res_next = {bus.fs_diff, r_res[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; clear always returns to IDLE and drops any start.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = StRun;
      end
      StRun: begin
        if (bus.clear)   w_state_d = StIdle;
        else if (w_last) w_state_d = StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Datapath: operand shifters, result assembly, borrow recirculation, counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sa         <= '0;
      r_sb         <= '0;
      r_res        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_bor        <= 1'b0;
      r_cnt        <= '0;
    end else if (bus.clear) begin
      // Abort: visible results are kept, only sequencing state is zeroed.
      r_bor <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sa  <= bus.a;
      r_sb  <= bus.b;
      r_bor <= 1'b0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      r_res <= w_res_next;
      r_bor <= bus.fs_borout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff       <= w_res_next;
        r_borrow_out <= bus.fs_borout;
      end
    end
  end

  // Status and cell drive; the cell inputs are quiet outside RUN.
  always_comb begin
    bus.ready      = (r_state == StIdle);
    bus.busy       = (r_state == StRun);
    bus.done       = (r_state == StDone);
    bus.diff       = r_diff;
    bus.borrow_out = r_borrow_out;
    bus.fs_x       = 1'b0;
    bus.fs_y       = 1'b0;
    bus.fs_borin   = 1'b0;
    if (r_state == StRun) begin
      bus.fs_x     = r_sa[0];
      bus.fs_y     = r_sb[0];
      bus.fs_borin = r_bor;
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl with an external full-subtractor cell.
module tb_serial_sub_ctrl;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bor;
  } exp_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // The shared combinational full-subtractor cell.
  assign bus.fs_diff   = bus.fs_x ^ bus.fs_y ^ bus.fs_borin;
  assign bus.fs_borout = (~bus.fs_x & bus.fs_y) | (~(bus.fs_x ^ bus.fs_y) & bus.fs_borin);

  int unsigned      checks = 0;
  int unsigned      errors = 0;
  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] held_diff = '0;
  logic             held_bor = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation on each done pulse, otherwise results must hold.
  initial begin
    forever begin
      @(negedge clock);
      if (!resetn) begin
        held_diff = '0;
        held_bor  = 1'b0;
      end else if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          mon_e = exp_q.pop_front();
          check("diff", 32'(bus.diff), 32'(mon_e.diff));
          check("borrow_out", 32'(bus.borrow_out), 32'(mon_e.bor));
          held_diff = mon_e.diff;
          held_bor  = mon_e.bor;
        end
        check("done_ready", 32'(bus.ready), 0);
        check("done_busy", 32'(bus.busy), 0);
        check("done_fs_zero", 32'({bus.fs_x, bus.fs_y, bus.fs_borin}), 0);
      end else begin
        check("diff_hold", 32'(bus.diff), 32'(held_diff));
        check("borrow_hold", 32'(bus.borrow_out), 32'(held_bor));
      end
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int unsigned mod;
    mod    = 1 << WIDTH;
    e.diff = WIDTH'((32'(a) + mod - 32'(b)) % mod);
    e.bor  = (32'(a) < 32'(b));
    exp_q.push_back(e);
  endtask

  // Drive a start pulse; returns just after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clock);
    check("ready_idle", 32'(bus.ready), 1);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // Full operation with per-bit cell drive checks and latency check.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] vx;
    logic [WIDTH-1:0] vy;
    logic [WIDTH-1:0] vb;
    logic [WIDTH-1:0] eb;
    int nb;
    int at;
    bit seen;
    vx = '0; vy = '0; vb = '0; eb = '0;
    nb = 0; at = -1; seen = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int unsigned m;
      m = (1 << i) - 1;
      // Borrow into bit i exists exactly when the low i bits of a are below those of b.
      eb[i] = ((32'(a) & m) < (32'(b) & m));
    end
    push_exp(a, b);
    launch(a, b);
    for (int k = 0; k < WIDTH + 6 && !seen; k++) begin
      if (k > 0) @(negedge clock);
      else @(negedge clock);
      if (bus.done) begin
        seen = 1'b1;
        at   = k;
      end else if (bus.busy) begin
        if (nb < WIDTH) begin
          vx[nb] = bus.fs_x;
          vy[nb] = bus.fs_y;
          vb[nb] = bus.fs_borin;
        end
        nb++;
        check("ready_low_in_run", 32'(bus.ready), 0);
      end
    end
    check("done_seen", 32'(seen), 1);
    check("done_latency", 32'(at), WIDTH);
    check("busy_cycles", 32'(nb), WIDTH);
    check("fs_x_bits", 32'(vx), 32'(a));
    check("fs_y_bits", 32'(vy), 32'(b));
    check("fs_borin_bits", 32'(vb), 32'(eb));
    @(negedge clock);
    check("ready_after", 32'(bus.ready), 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset values while reset is held.
    #12;
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_diff", 32'(bus.diff), 0);
    check("rst_borrow", 32'(bus.borrow_out), 0);
    check("rst_fs", 32'({bus.fs_x, bus.fs_y, bus.fs_borin}), 0);
    resetn = 1'b1;

    // Directed cases.
    run_op(8'd100, 8'd37);
    run_op(8'd5, 8'd9);
    run_op(8'd0, 8'd0);
    run_op(8'hFF, 8'hFF);
    run_op(8'd0, 8'd1);
    run_op(8'h80, 8'h7F);

    // Start held through RUN and DONE with changing operands is ignored.
    push_exp(8'd200, 8'd13);
    launch(8'd200, 8'd13);
    bus.start = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < WIDTH + 6 && !seen; k++) begin
        @(negedge clock);
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
        if (bus.done) seen = 1'b1;
        else check("ign_ready_low", 32'(bus.ready), 0);
      end
      check("ign_done_seen", 32'(seen), 1);
    end
    bus.start = 1'b0;
    repeat (4) @(negedge clock);
    check("ign_idle", 32'(bus.ready), 1);

    // Asynchronous reset during RUN cycle 3.
    launch(WIDTH'($urandom), WIDTH'($urandom));
    repeat (3) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("arst_ready", 32'(bus.ready), 1);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_diff", 32'(bus.diff), 0);
    check("arst_borrow", 32'(bus.borrow_out), 0);
    check("arst_fs", 32'({bus.fs_x, bus.fs_y, bus.fs_borin}), 0);
    @(negedge clock);
    #1 resetn = 1'b1;
    run_op(8'd20, 8'd7);

    // Clear at RUN cycle 5 together with start.
    run_op(8'd100, 8'd37);
    launch(WIDTH'($urandom), WIDTH'($urandom));
    repeat (5) @(negedge clock);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    @(posedge clock);
    #1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    @(negedge clock);
    check("clr_ready", 32'(bus.ready), 1);
    check("clr_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clock);
    check("clr_still_idle", 32'(bus.ready), 1);
    run_op(8'd77, 8'd200);

    // Randomized operations.
    for (int n = 0; n < 24; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom));
    end

    repeat (3) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
